// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding-mode codes, operand classes and exponent bias.
package fpu_pkg;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    typedef enum logic [2:0] {
        CLS_ZERO = 3'd0,
        CLS_SUBN = 3'd1,
        CLS_NORM = 3'd2,
        CLS_INF  = 3'd3,
        CLS_NAN  = 3'd4
    } fp_class_e;

    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/fp_round_inc.sv
// Round-increment decision from mode, sign, result LSB, guard and sticky.
// Unknown mode codes fall back to round-to-nearest-even.
module fp_round_inc
    import fpu_pkg::*;
(
    input  logic [2:0] rm_i,
    input  logic       sign_i,
    input  logic       lsb_i,
    input  logic       g_i,
    input  logic       s_i,
    output logic       inc_o
);

    always_comb begin
        case (rm_i)
            RM_RTZ:  inc_o = 1'b0;
            RM_RDN:  inc_o = sign_i & (g_i | s_i);
            RM_RUP:  inc_o = ~sign_i & (g_i | s_i);
            RM_RMM:  inc_o = g_i;
            default: inc_o = g_i & (s_i | lsb_i);
        endcase
    end

endmodule

// File: rtl/fp_to_int_pipe.sv
// Three-stage IEEE-754 to integer converter: unpack/classify, align, round/saturate.
// One global advance enable stalls every stage together when the output is blocked.
module fp_to_int_pipe
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int INT_W = 32,
    parameter int XLEN  = EXP_W + MAN_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  A,
    input  logic [2:0]       rm,
    input  logic             is_unsigned,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [INT_W-1:0] result,
    output logic             flag_nv,
    output logic             flag_nx
);

    localparam int BIAS = bias(EXP_W);
    localparam int SH_W = INT_W + MAN_W + 1;

    localparam logic [INT_W+1:0] MAG_SPOS = {3'b000, {(INT_W-1){1'b1}}};
    localparam logic [INT_W+1:0] MAG_SNEG = {3'b001, {(INT_W-1){1'b0}}};
    localparam logic [INT_W+1:0] MAG_UMAX = {2'b00, {INT_W{1'b1}}};
    localparam logic [INT_W-1:0] SAT_SMAX = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic [INT_W-1:0] SAT_SMIN = {1'b1, {(INT_W-1){1'b0}}};

    logic [3:1] vld_q;
    logic       adv;

    assign adv       = ~vld_q[3] | out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[3];

    // S1 unpack/classify
    logic             s1_sign_q, s1_sign_d;
    logic [EXP_W-1:0] s1_exp_q,  s1_exp_d;
    logic [MAN_W:0]   s1_man_q,  s1_man_d;
    fp_class_e        s1_cls_q,  s1_cls_d;
    logic [2:0]       s1_rm_q;
    logic             s1_uns_q;

    assign s1_sign_d = A[XLEN-1];
    assign s1_exp_d  = A[XLEN-2:MAN_W];
    assign s1_man_d  = {|s1_exp_d, A[MAN_W-1:0]};

    always_comb begin
        if (s1_exp_d == '0)
            s1_cls_d = (A[MAN_W-1:0] == '0) ? CLS_ZERO : CLS_SUBN;
        else if (s1_exp_d == '1)
            s1_cls_d = (A[MAN_W-1:0] == '0) ? CLS_INF : CLS_NAN;
        else
            s1_cls_d = CLS_NORM;
    end

    // S2 align
    logic             s2_sign_q, s2_nan_q, s2_inf_q, s2_povf_q;
    logic [INT_W:0]   s2_int_q,  s2_int_d;
    logic             s2_g_q,    s2_g_d;
    logic             s2_s_q,    s2_s_d;
    logic             s2_povf_d;
    logic [2:0]       s2_rm_q;
    logic             s2_uns_q;
    logic [SH_W-1:0]  sh_v;
    int               e_s;

    always_comb begin
        e_s       = int'(s1_exp_q) - BIAS;
        sh_v      = '0;
        s2_int_d  = '0;
        s2_g_d    = 1'b0;
        s2_s_d    = 1'b0;
        s2_povf_d = 1'b0;
        if (s1_cls_q == CLS_INF || s1_cls_q == CLS_NAN) begin
            s2_povf_d = 1'b0;
        end else if (e_s < -1) begin
            // Subnormals land here too: exponent field 0 is far below -1.
            s2_s_d = |s1_man_q;
        end else if (e_s == -1) begin
            s2_g_d = s1_man_q[MAN_W];
            s2_s_d = |s1_man_q[MAN_W-1:0];
        end else if (e_s > INT_W) begin
            s2_povf_d = 1'b1;
        end else begin
            sh_v     = SH_W'(s1_man_q) << e_s;
            s2_int_d = sh_v[SH_W-1:MAN_W];
            s2_g_d   = sh_v[MAN_W-1];
            s2_s_d   = |sh_v[MAN_W-2:0];
        end
    end

    // S3 round/saturate
    logic             inc;
    logic [INT_W+1:0] mag;
    logic             pos_sat, neg_sat;
    logic [INT_W-1:0] result_q, res_d;
    logic             nv_q, nv_d;
    logic             nx_q, nx_d;

    fp_round_inc u_round_inc (
        .rm_i   (s2_rm_q),
        .sign_i (s2_sign_q),
        .lsb_i  (s2_int_q[0]),
        .g_i    (s2_g_q),
        .s_i    (s2_s_q),
        .inc_o  (inc)
    );

    // Extra carry bit guards against wrap when the aligned integer is all ones.
    assign mag = {1'b0, s2_int_q} + {{(INT_W+1){1'b0}}, inc};

    always_comb begin
        pos_sat = 1'b0;
        neg_sat = 1'b0;
        if (s2_nan_q) begin
            pos_sat = 1'b1;
        end else if (s2_inf_q || s2_povf_q) begin
            pos_sat = ~s2_sign_q;
            neg_sat = s2_sign_q;
        end else if (s2_uns_q) begin
            if (s2_sign_q && mag != '0)
                neg_sat = 1'b1;
            else if (mag > MAG_UMAX)
                pos_sat = 1'b1;
        end else begin
            if (!s2_sign_q && mag > MAG_SPOS)
                pos_sat = 1'b1;
            else if (s2_sign_q && mag > MAG_SNEG)
                neg_sat = 1'b1;
        end

        nv_d = pos_sat | neg_sat;
        if (pos_sat)
            res_d = s2_uns_q ? '1 : SAT_SMAX;
        else if (neg_sat)
            res_d = s2_uns_q ? '0 : SAT_SMIN;
        else if (s2_sign_q)
            res_d = -mag[INT_W-1:0];
        else
            res_d = mag[INT_W-1:0];
        nx_d = (s2_g_q | s2_s_q) & ~nv_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q     <= '0;
            s1_sign_q <= 1'b0;
            s1_exp_q  <= '0;
            s1_man_q  <= '0;
            s1_cls_q  <= CLS_ZERO;
            s1_rm_q   <= RM_RNE;
            s1_uns_q  <= 1'b0;
            s2_sign_q <= 1'b0;
            s2_nan_q  <= 1'b0;
            s2_inf_q  <= 1'b0;
            s2_povf_q <= 1'b0;
            s2_int_q  <= '0;
            s2_g_q    <= 1'b0;
            s2_s_q    <= 1'b0;
            s2_rm_q   <= RM_RNE;
            s2_uns_q  <= 1'b0;
            result_q  <= '0;
            nv_q      <= 1'b0;
            nx_q      <= 1'b0;
        end else if (adv) begin
            vld_q <= {vld_q[2:1], in_valid};
            if (in_valid) begin
                s1_sign_q <= s1_sign_d;
                s1_exp_q  <= s1_exp_d;
                s1_man_q  <= s1_man_d;
                s1_cls_q  <= s1_cls_d;
                s1_rm_q   <= rm;
                s1_uns_q  <= is_unsigned;
            end
            if (vld_q[1]) begin
                s2_sign_q <= s1_sign_q;
                s2_nan_q  <= (s1_cls_q == CLS_NAN);
                s2_inf_q  <= (s1_cls_q == CLS_INF);
                s2_povf_q <= s2_povf_d;
                s2_int_q  <= s2_int_d;
                s2_g_q    <= s2_g_d;
                s2_s_q    <= s2_s_d;
                s2_rm_q   <= s1_rm_q;
                s2_uns_q  <= s1_uns_q;
            end
            if (vld_q[2]) begin
                result_q <= res_d;
                nv_q     <= nv_d;
                nx_q     <= nx_d;
            end
        end
    end

    assign result  = result_q;
    assign flag_nv = nv_q;
    assign flag_nx = nx_q;

endmodule

// File: tb/tb_fp_to_int_pipe.sv
// Self-checking bench for fp_to_int_pipe (binary32 -> 32-bit integer).
// Reference model works from the real value: integer part plus a fraction class.
module tb_fp_to_int_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [2:0]  rm;
    logic        is_unsigned;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        flag_nv;
    logic        flag_nx;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] r;
        logic        nv;
        logic        nx;
    } exp_t;

    typedef struct packed {
        logic [31:0] a;
        logic [2:0]  rm;
        logic        uns;
        logic [31:0] r;
        logic        nv;
        logic        nx;
    } vec_t;

    fp_to_int_pipe dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .A           (A),
        .rm          (rm),
        .is_unsigned (is_unsigned),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .flag_nv     (flag_nv),
        .flag_nx     (flag_nx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // value = man * 2^k; fc: 0 exact, 1 below half, 2 exactly half, 3 above half
    function automatic exp_t ref_conv(input logic [31:0] a, input logic [2:0] rmode, input logic uns);
        exp_t   e;
        int     ex, k, fc;
        longint man, q, rem, half, mag;
        bit     up, neg;
        neg  = a[31];
        ex   = int'(a[30:23]);
        man  = longint'(a[22:0]);
        e.r  = '0;
        e.nv = 1'b0;
        e.nx = 1'b0;
        if (ex != 0) man = man + 64'sd8388608;
        if (ex == 255) begin
            e.nv = 1'b1;
            if (a[22:0] != 0 || !neg) e.r = uns ? 32'hFFFFFFFF : 32'h7FFFFFFF;
            else                      e.r = uns ? 32'h00000000 : 32'h80000000;
            return e;
        end
        k = ((ex == 0) ? 1 : ex) - 150;
        if (k > 30) begin
            q = 64'sd1 <<< 41; fc = 0;
        end else if (k >= 0) begin
            q = man <<< k; fc = 0;
        end else if (k < -30) begin
            q = 0; fc = (man == 0) ? 0 : 1;
        end else begin
            q    = man >>> (-k);
            rem  = man - (q <<< (-k));
            half = 64'sd1 <<< (-k - 1);
            fc   = (rem == 0) ? 0 : (rem < half) ? 1 : (rem == half) ? 2 : 3;
        end
        case (rmode)
            3'd1:    up = 1'b0;
            3'd2:    up = neg && fc != 0;
            3'd3:    up = !neg && fc != 0;
            3'd4:    up = fc >= 2;
            default: up = (fc == 3) || (fc == 2 && q[0]);
        endcase
        mag = q + (up ? 64'sd1 : 64'sd0);
        if (uns) begin
            if (neg && mag != 0)             begin e.nv = 1'b1; e.r = 32'h00000000; end
            else if (mag > 64'sd4294967295)  begin e.nv = 1'b1; e.r = 32'hFFFFFFFF; end
            else                             e.r = mag[31:0];
        end else begin
            if (!neg && mag > 64'sd2147483647)     begin e.nv = 1'b1; e.r = 32'h7FFFFFFF; end
            else if (neg && mag > 64'sd2147483648) begin e.nv = 1'b1; e.r = 32'h80000000; end
            else e.r = neg ? 32'(-mag) : mag[31:0];
        end
        e.nx = (fc != 0) && !e.nv;
        return e;
    endfunction

    task automatic test_reset();
        rst_n = 1'b1; in_valid = 1'b0; A = '0; rm = '0; is_unsigned = 1'b0; out_ready = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        n_tests++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result got=%h want=00000000", result); end
        n_tests++; if (flag_nv !== 1'b0) begin n_fail++; $display("FAIL reset_nv got=%b want=0", flag_nv); end
        n_tests++; if (flag_nx !== 1'b0) begin n_fail++; $display("FAIL reset_nx got=%b want=0", flag_nx); end
        rst_n = 1'b1;
        @(negedge clk); #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_release_valid got=%b want=0", out_valid); end
    endtask

    task automatic test_directed();
        vec_t v [21];
        v = '{
            '{32'h404CCCCC, 3'd0, 1'b0, 32'h00000003, 1'b0, 1'b1},
            '{32'hBF000000, 3'd0, 1'b0, 32'h00000000, 1'b0, 1'b1},
            '{32'hBF000000, 3'd2, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b1},
            '{32'h40200000, 3'd0, 1'b0, 32'h00000002, 1'b0, 1'b1},
            '{32'h40200000, 3'd4, 1'b0, 32'h00000003, 1'b0, 1'b1},
            '{32'hC28C3EFA, 3'd1, 1'b0, 32'hFFFFFFBA, 1'b0, 1'b1},
            '{32'h7FC00000, 3'd0, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0},
            '{32'h501502F9, 3'd0, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0},
            '{32'hCF000000, 3'd0, 1'b0, 32'h80000000, 1'b0, 1'b0},
            '{32'h4F000000, 3'd0, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0},
            '{32'hBF800000, 3'd0, 1'b1, 32'h00000000, 1'b1, 1'b0},
            '{32'hBE800000, 3'd1, 1'b1, 32'h00000000, 1'b0, 1'b1},
            '{32'hFF800000, 3'd0, 1'b0, 32'h80000000, 1'b1, 1'b0},
            '{32'h80000000, 3'd0, 1'b0, 32'h00000000, 1'b0, 1'b0},
            '{32'h3FC00000, 3'd3, 1'b0, 32'h00000002, 1'b0, 1'b1},
            '{32'hBFC00000, 3'd3, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b1},
            '{32'h40200000, 3'd7, 1'b0, 32'h00000002, 1'b0, 1'b1},
            '{32'h4F7FFFFF, 3'd0, 1'b1, 32'hFFFFFF00, 1'b0, 1'b0},
            '{32'h4F800000, 3'd0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0},
            '{32'h7FC00000, 3'd0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0},
            '{32'hCF000001, 3'd0, 1'b0, 32'h80000000, 1'b1, 1'b0}
        };
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            A = v[i].a; rm = v[i].rm; is_unsigned = v[i].uns; in_valid = 1'b1; out_ready = 1'b1;
            #1;
            n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL dir%0d_in_ready got=%b want=1", i, in_ready); end
            @(negedge clk); in_valid = 1'b0; #1;
            n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dir%0d_lat1 out_valid got=%b want=0", i, out_valid); end
            @(negedge clk); #1;
            n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dir%0d_lat2 out_valid got=%b want=0", i, out_valid); end
            @(negedge clk); #1;
            n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL dir%0d_lat3 out_valid got=%b want=1", i, out_valid); end
            n_tests++;
            if (result !== v[i].r || flag_nv !== v[i].nv || flag_nx !== v[i].nx) begin
                n_fail++;
                $display("FAIL dir%0d_value A=%h got r=%h nv=%b nx=%b want r=%h nv=%b nx=%b",
                         i, v[i].a, result, flag_nv, flag_nx, v[i].r, v[i].nv, v[i].nx);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] ops [5];
        exp_t        q [$];
        int          sent, got;
        bit          saw_low;
        ops = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
        sent = 0; got = 0; saw_low = 1'b0;
        for (int c = 0; c < 40 && got < 5; c++) begin
            @(negedge clk);
            in_valid = (sent < 5); A = ops[sent % 5]; rm = 3'd0; is_unsigned = 1'b0;
            out_ready = !(c >= 4 && c < 10);
            #1;
            if (!in_ready) saw_low = 1'b1;
            if (out_valid) begin
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL bp_spurious cycle=%0d got r=%h want no output", c, result);
                end else if (result !== q[0].r || flag_nv !== q[0].nv || flag_nx !== q[0].nx) begin
                    n_fail++; $display("FAIL bp_value cycle=%0d got r=%h nv=%b nx=%b want r=%h nv=%b nx=%b",
                                       c, result, flag_nv, flag_nx, q[0].r, q[0].nv, q[0].nx);
                end
                if (out_ready && q.size() != 0) begin void'(q.pop_front()); got++; end
            end
            if (in_valid && in_ready) begin q.push_back(ref_conv(A, rm, is_unsigned)); sent++; end
        end
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
        n_tests++; if (!saw_low) begin n_fail++; $display("FAIL bp_in_ready_drop got=never low want=low during stall"); end
        n_tests++; if (got != 5) begin n_fail++; $display("FAIL bp_count got=%0d want=5", got); end
        for (int c = 0; c < 4; c++) begin
            #1;
            n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_duplicate got out_valid=%b want=0", out_valid); end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        exp_t        q [$];
        exp_t        e;
        int          sent, got, ex;
        logic [31:0] nxt;
        sent = 0; got = 0;
        nxt = 32'h0;
        for (int c = 0; c < 5000 && got < 300; c++) begin
            @(negedge clk);
            if (!(in_valid && in_ready) && in_valid) begin
                A = A;
            end else begin
                ex  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(118, 162));
                nxt = {1'($urandom), 8'(ex), 23'($urandom)};
                A = nxt; rm = 3'($urandom_range(0, 7)); is_unsigned = 1'($urandom);
                in_valid = (sent < 300) && ($urandom_range(0, 3) != 0);
            end
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (out_valid) begin
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL rnd_spurious cycle=%0d got r=%h want no output", c, result);
                end else if (result !== q[0].r || flag_nv !== q[0].nv || flag_nx !== q[0].nx) begin
                    n_fail++; $display("FAIL rnd_value cycle=%0d got r=%h nv=%b nx=%b want r=%h nv=%b nx=%b",
                                       c, result, flag_nv, flag_nx, q[0].r, q[0].nv, q[0].nx);
                end
                if (out_ready && q.size() != 0) begin void'(q.pop_front()); got++; end
            end
            if (in_valid && in_ready) begin
                e = ref_conv(A, rm, is_unsigned);
                q.push_back(e);
                sent++;
            end
        end
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
        n_tests++; if (got != 300) begin n_fail++; $display("FAIL rnd_count got=%0d want=300", got); end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] ops [3];
        int          stale;
        ops = '{32'h3F800000, 32'h40000000, 32'h40400000};
        stale = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            A = ops[i]; rm = 3'd0; is_unsigned = 1'b0; in_valid = 1'b1;
        end
        @(negedge clk); in_valid = 1'b0; #1;
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_prefill out_valid got=%b want=1", out_valid); end
        #1 rst_n = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_async out_valid got=%b want=0", out_valid); end
        n_tests++; if (result !== 32'h0) begin n_fail++; $display("FAIL mid_async result got=%h want=00000000", result); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            if (out_valid !== 1'b0) stale++;
        end
        n_tests++; if (stale != 0) begin n_fail++; $display("FAIL mid_stale got=%0d stale cycles want=0", stale); end
        @(negedge clk);
        A = 32'h42F60000; rm = 3'd0; is_unsigned = 1'b0; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_after out_valid got=%b want=1", out_valid); end
        n_tests++;
        if (result !== 32'd123 || flag_nv !== 1'b0 || flag_nx !== 1'b0) begin
            n_fail++; $display("FAIL mid_after_value got r=%h nv=%b nx=%b want r=0000007b nv=0 nx=0", result, flag_nv, flag_nx);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
